event_log_writer: RTL and testbench

EVENT_LOG_WRITER -- requirements
Module: event_log_writer

---
 rtl/event_log_pkg.sv | 39 +++
 rtl/event_log_fifo.sv | 71 +++++++
 rtl/event_log_writer.sv | 226 ++++++++++++++++++++++
 tb/tb_event_log_writer.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/event_log_pkg.sv
// -----------------------------------------------------------------------------
// event_log_pkg
// Shared definitions for the event log writer: log geometry, log-entry field
// positions, FSM state encoding and the entry packing helper.
// No ports (package).
// -----------------------------------------------------------------------------
package event_log_pkg;

    localparam int LOG_DEPTH  = 1024;
    localparam int LOG_ADDR_W = 10;
    localparam int ENTRY_W    = 32;

    // Log entry layout: {code, data, stamp}
    localparam int CODE_MSB  = 31;
    localparam int CODE_LSB  = 24;
    localparam int DATA_MSB  = 23;
    localparam int DATA_LSB  = 16;
    localparam int STAMP_MSB = 15;
    localparam int STAMP_LSB = 0;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } logState_e;

    function automatic logic [ENTRY_W-1:0] packEntry(
        input logic [7:0]  code,
        input logic [7:0]  data,
        input logic [15:0] stamp
    );
        logic [ENTRY_W-1:0] entry;
        entry                     = 32'h0000_0000;
        entry[CODE_MSB:CODE_LSB]  = code;
        entry[DATA_MSB:DATA_LSB]  = data;
        entry[STAMP_MSB:STAMP_LSB] = stamp;
        return entry;
    endfunction

endpackage

// File: rtl/event_log_fifo.sv
// -----------------------------------------------------------------------------
// event_log_fifo
// Show-ahead staging FIFO for log entries. The head entry is always visible on
// ovHeadData while oEmpty=0; a pop simply advances the read pointer.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
// Ports:
//   iClk, iRst        clock, synchronous active-high reset
//   iPush, ivPushData write strobe and entry
//   iPop              consume head entry
//   ovHeadData        current head entry
//   oEmpty, oFull     occupancy flags
// -----------------------------------------------------------------------------
module event_log_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iPush,
    input  logic [WIDTH-1:0] ivPushData,
    input  logic             iPop,
    output logic [WIDTH-1:0] ovHeadData,
    output logic             oEmpty,
    output logic             oFull
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    rdPtr_r;
    logic [AW-1:0]    wrPtr_r;
    logic [AW:0]      count_r;
    logic             doPush_s;
    logic             doPop_s;

    assign oEmpty     = (count_r == {(AW + 1){1'b0}});
    assign oFull      = (count_r == FULL_COUNT);
    assign doPop_s    = iPop && !oEmpty;
    assign doPush_s   = iPush && (!oFull || doPop_s);
    assign ovHeadData = mem_r[rdPtr_r];

    // Entry storage; contents need no reset since count_r gates visibility.
    always_ff @(posedge iClk) begin
        if (doPush_s) begin
            mem_r[wrPtr_r] <= ivPushData;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            rdPtr_r <= {AW{1'b0}};
            wrPtr_r <= {AW{1'b0}};
            count_r <= {(AW + 1){1'b0}};
        end else begin
            if (doPush_s) begin
                wrPtr_r <= wrPtr_r + {{(AW - 1){1'b0}}, 1'b1};
            end
            if (doPop_s) begin
                rdPtr_r <= rdPtr_r + {{(AW - 1){1'b0}}, 1'b1};
            end
            case ({doPush_s, doPop_s})
                2'b10:   count_r <= count_r + {{AW{1'b0}}, 1'b1};
                2'b01:   count_r <= count_r - {{AW{1'b0}}, 1'b1};
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/event_log_writer.sv
// -----------------------------------------------------------------------------
// event_log_writer
// Captures one-cycle events into a staging FIFO and writes them as 32-bit
// entries {code, data, stamp} to a 1024-word log RAM, one per cycle. A clear
// request sweeps the whole RAM with zeros and restarts logging at index 0.
// An event arriving on an idle cycle with an empty FIFO bypasses the FIFO so
// the RAM write appears on the very next cycle.
// Build option EVENT_LOG_TIMESTAMP_EN: stamp is a free-running iTick counter;
// otherwise stamp is a per-accepted-event sequence number and iTick is unused.
// Ports:
//   iClk, iRst                   clock, synchronous active-high reset
//   iEventValid, ivEventCode,
//   ivEventData                  event strobe and payload
//   iTick                        timestamp prescale tick
//   iClearReq                    log clear request
//   ovAddress, oAppWE, ovAppData log RAM write port (registered)
//   ovWrPtr                      next free log index
//   oWrapped, oOverflow          sticky status flags
//   oClearBusy                   clear sweep in progress
// -----------------------------------------------------------------------------
module event_log_writer
    import event_log_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  iClk,
    input  logic                  iRst,
    input  logic                  iEventValid,
    input  logic [7:0]            ivEventCode,
    input  logic [7:0]            ivEventData,
    input  logic                  iTick,
    input  logic                  iClearReq,
    output logic [LOG_ADDR_W-1:0] ovAddress,
    output logic                  oAppWE,
    output logic [ENTRY_W-1:0]    ovAppData,
    output logic [LOG_ADDR_W-1:0] ovWrPtr,
    output logic                  oWrapped,
    output logic                  oOverflow,
    output logic                  oClearBusy
);

    logState_e             state_r;
    logState_e             stateNext_s;
    logic [LOG_ADDR_W:0]   clrCnt_r;      // MSB set marks the post-sweep exit cycle
    logic [LOG_ADDR_W-1:0] wrPtr_r;
    logic [15:0]           stamp_r;

    logic [ENTRY_W-1:0]    newEntry_s;
    logic [ENTRY_W-1:0]    fifoHead_s;
    logic                  fifoEmpty_s;
    logic                  fifoFull_s;
    logic                  fifoPush_s;
    logic                  fifoPop_s;
    logic                  bypass_s;
    logic                  accept_s;
    logic                  drop_s;
    logic                  writeEn_s;
    logic [LOG_ADDR_W-1:0] writeAddr_s;
    logic [ENTRY_W-1:0]    writeData_s;
    logic                  advancePtr_s;
    logic                  clearStart_s;
    logic                  clearExit_s;

    assign newEntry_s = packEntry(ivEventCode, ivEventData, stamp_r);
    assign fifoPush_s = iEventValid && !bypass_s && (!fifoFull_s || fifoPop_s);
    assign accept_s   = bypass_s || fifoPush_s;
    assign drop_s     = iEventValid && !accept_s;
    assign ovWrPtr    = wrPtr_r;

    event_log_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) uFifo (
        .iClk       (iClk),
        .iRst       (iRst),
        .iPush      (fifoPush_s),
        .ivPushData (newEntry_s),
        .iPop       (fifoPop_s),
        .ovHeadData (fifoHead_s),
        .oEmpty     (fifoEmpty_s),
        .oFull      (fifoFull_s)
    );

    // FSM state register.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= stateNext_s;
        end
    end

    // FSM next-state: clear request wins in IDLE; sweep ends on the exit cycle.
    always_comb begin
        stateNext_s = state_r;
        case (state_r)
            ST_IDLE:  stateNext_s = iClearReq ? ST_CLEAR : ST_IDLE;
            ST_CLEAR: stateNext_s = clrCnt_r[LOG_ADDR_W] ? ST_IDLE : ST_CLEAR;
            default:  stateNext_s = ST_IDLE;
        endcase
    end

    // FSM outputs: select what (if anything) is written this cycle.
    // The first zero write is issued from IDLE so the sweep occupies exactly
    // 1024 consecutive write cycles, followed by one write-free exit cycle.
    always_comb begin
        fifoPop_s    = 1'b0;
        bypass_s     = 1'b0;
        writeEn_s    = 1'b0;
        writeAddr_s  = wrPtr_r;
        writeData_s  = 32'h0000_0000;
        advancePtr_s = 1'b0;
        clearStart_s = 1'b0;
        clearExit_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (iClearReq) begin
                    clearStart_s = 1'b1;
                    writeEn_s    = 1'b1;
                    writeAddr_s  = {LOG_ADDR_W{1'b0}};
                end else if (!fifoEmpty_s) begin
                    fifoPop_s    = 1'b1;
                    writeEn_s    = 1'b1;
                    writeData_s  = fifoHead_s;
                    advancePtr_s = 1'b1;
                end else if (iEventValid) begin
                    bypass_s     = 1'b1;
                    writeEn_s    = 1'b1;
                    writeData_s  = newEntry_s;
                    advancePtr_s = 1'b1;
                end else begin
                    writeEn_s = 1'b0;
                end
            end
            ST_CLEAR: begin
                if (clrCnt_r[LOG_ADDR_W]) begin
                    clearExit_s = 1'b1;
                end else begin
                    writeEn_s   = 1'b1;
                    writeAddr_s = clrCnt_r[LOG_ADDR_W-1:0];
                end
            end
            default: begin
                writeEn_s = 1'b0;
            end
        endcase
    end

    // Registered RAM port, pointer, sweep counter and status flags.
    // oOverflow is cleared when a sweep starts, so it reports drops that
    // occurred since the most recent clear began (including during the sweep).
    always_ff @(posedge iClk) begin
        if (iRst) begin
            oAppWE     <= 1'b0;
            ovAddress  <= {LOG_ADDR_W{1'b0}};
            ovAppData  <= 32'h0000_0000;
            wrPtr_r    <= {LOG_ADDR_W{1'b0}};
            clrCnt_r   <= {(LOG_ADDR_W + 1){1'b0}};
            oWrapped   <= 1'b0;
            oOverflow  <= 1'b0;
            oClearBusy <= 1'b0;
        end else begin
            oAppWE <= writeEn_s;
            if (writeEn_s) begin
                ovAddress <= writeAddr_s;
                ovAppData <= writeData_s;
            end

            if (clearStart_s) begin
                clrCnt_r <= {{LOG_ADDR_W{1'b0}}, 1'b1};
            end else if (clearExit_s) begin
                clrCnt_r <= {(LOG_ADDR_W + 1){1'b0}};
            end else if (state_r == ST_CLEAR) begin
                clrCnt_r <= clrCnt_r + {{LOG_ADDR_W{1'b0}}, 1'b1};
            end

            if (clearExit_s) begin
                wrPtr_r  <= {LOG_ADDR_W{1'b0}};
                oWrapped <= 1'b0;
            end else if (advancePtr_s) begin
                wrPtr_r <= wrPtr_r + {{(LOG_ADDR_W - 1){1'b0}}, 1'b1};
                if (wrPtr_r == LOG_ADDR_W'(LOG_DEPTH - 1)) begin
                    oWrapped <= 1'b1;
                end
            end

            if (clearStart_s) begin
                oOverflow <= drop_s;
            end else if (drop_s) begin
                oOverflow <= 1'b1;
            end

            if (clearStart_s) begin
                oClearBusy <= 1'b1;
            end else if (clearExit_s) begin
                oClearBusy <= 1'b0;
            end
        end
    end

`ifdef EVENT_LOG_TIMESTAMP_EN
    // Free-running timestamp, advanced by the prescale tick.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            stamp_r <= 16'h0000;
        end else if (iTick) begin
            stamp_r <= stamp_r + 16'h0001;
        end
    end
`else
    logic unusedTick_s;
    assign unusedTick_s = iTick;

    // Sequence number per accepted event, restarted when a sweep completes.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            stamp_r <= 16'h0000;
        end else if (clearExit_s) begin
            stamp_r <= 16'h0000;
        end else if (accept_s) begin
            stamp_r <= stamp_r + 16'h0001;
        end
    end
`endif

endmodule

// File: tb/tb_event_log_writer.sv
module tb_event_log_writer;

    typedef struct {
        logic [9:0]  addr;
        logic [31:0] data;
    } expWrite_t;

    logic        iClk;
    logic        iRst;
    logic        iEventValid;
    logic [7:0]  ivEventCode;
    logic [7:0]  ivEventData;
    logic        iTick;
    logic        iClearReq;
    logic [9:0]  ovAddress;
    logic        oAppWE;
    logic [31:0] ovAppData;
    logic [9:0]  ovWrPtr;
    logic        oWrapped;
    logic        oOverflow;
    logic        oClearBusy;

    expWrite_t   expQ[$];
    int          vectorCnt = 0;
    int          missCnt   = 0;
    logic [9:0]  modelPtr  = 10'd0;
    logic [15:0] modelSeq  = 16'h0000;
    logic [15:0] tickCnt   = 16'h0000;
    logic [31:0] lastWord;

    event_log_writer #(.FIFO_DEPTH(4)) dut (
        .iClk        (iClk),
        .iRst        (iRst),
        .iEventValid (iEventValid),
        .ivEventCode (ivEventCode),
        .ivEventData (ivEventData),
        .iTick       (iTick),
        .iClearReq   (iClearReq),
        .ovAddress   (ovAddress),
        .oAppWE      (oAppWE),
        .ovAppData   (ovAppData),
        .ovWrPtr     (ovWrPtr),
        .oWrapped    (oWrapped),
        .oOverflow   (oOverflow),
        .oClearBusy  (oClearBusy)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectorCnt++;
        if (got !== exp) begin
            missCnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge iClk);
        #1;
    endtask

    // Expected stamp for the next accepted event.
    task automatic nextStamp(output logic [15:0] s);
`ifdef EVENT_LOG_TIMESTAMP_EN
        s = tickCnt;
`else
        s = modelSeq;
        modelSeq = modelSeq + 16'h0001;
`endif
    endtask

    task automatic pushEvent(input logic [7:0] c, input logic [7:0] d);
        expWrite_t e;
        logic [15:0] s;
        nextStamp(s);
        e.addr = modelPtr;
        e.data = {c, d, s};
        expQ.push_back(e);
        lastWord = e.data;
        modelPtr = modelPtr + 10'd1;
    endtask

    task automatic pushClear();
        expWrite_t e;
        for (int a = 0; a < 1024; a++) begin
            e.addr = 10'(a);
            e.data = 32'h0000_0000;
            expQ.push_back(e);
        end
        modelPtr = 10'd0;
    endtask

    task automatic seqClearExit();
`ifndef EVENT_LOG_TIMESTAMP_EN
        modelSeq = 16'h0000;
`endif
    endtask

    task automatic waitClearDone();
        int k = 0;
        while (oClearBusy === 1'b1 && k < 1100) begin
            step();
            k++;
        end
        checkVal("clear_done", {31'd0, oClearBusy}, 32'd0);
        seqClearExit();
    endtask

    task automatic waitDrain();
        for (int k = 0; k < 20 && expQ.size() != 0; k++) step();
        checkVal("drain", expQ.size(), 32'd0);
    endtask

    // Scoreboard: every RAM write must match the next expected write.
    always @(negedge iClk) begin
        expWrite_t e;
        if (oAppWE === 1'b1) begin
            if (expQ.size() == 0) begin
                checkVal("spurious_we", {31'd0, oAppWE}, 32'd0);
            end else begin
                e = expQ.pop_front();
                checkVal("wr_addr", {22'd0, ovAddress}, {22'd0, e.addr});
                checkVal("wr_data", ovAppData, e.data);
            end
        end
    end

    initial begin
        iRst = 1'b1; iEventValid = 1'b0; ivEventCode = 8'h00; ivEventData = 8'h00;
        iTick = 1'b0; iClearReq = 1'b0;
        repeat (3) step();
        checkVal("rst_we",    {31'd0, oAppWE},     32'd0);
        checkVal("rst_addr",  {22'd0, ovAddress},  32'd0);
        checkVal("rst_data",  ovAppData,           32'd0);
        checkVal("rst_ptr",   {22'd0, ovWrPtr},    32'd0);
        checkVal("rst_wrap",  {31'd0, oWrapped},   32'd0);
        checkVal("rst_ovf",   {31'd0, oOverflow},  32'd0);
        checkVal("rst_busy",  {31'd0, oClearBusy}, 32'd0);
        iRst = 1'b0;
        step();

        // Single event, one-cycle latency.
        for (int t = 0; t < 7; t++) begin
            iTick = 1'b1; step(); tickCnt = tickCnt + 16'h0001;
            iTick = 1'b0; step();
        end
        iEventValid = 1'b1; ivEventCode = 8'hA5; ivEventData = 8'h3C;
        pushEvent(8'hA5, 8'h3C);
        step();
        iEventValid = 1'b0;
        checkVal("lat_we",   {31'd0, oAppWE},    32'd1);
        checkVal("lat_addr", {22'd0, ovAddress}, 32'd0);
        checkVal("lat_data", ovAppData,          lastWord);
        step();
        checkVal("one_ptr",  {22'd0, ovWrPtr},   32'd1);
        checkVal("one_we_off", {31'd0, oAppWE},  32'd0);

        // Six back-to-back events.
        for (int i = 0; i < 6; i++) begin
            iEventValid = 1'b1; ivEventCode = 8'(8'h10 + i); ivEventData = 8'(8'hF0 ^ i);
            pushEvent(ivEventCode, ivEventData);
            step();
            checkVal("b2b_we", {31'd0, oAppWE}, 32'd1);
        end
        iEventValid = 1'b0;
        waitDrain();
        checkVal("b2b_ovf", {31'd0, oOverflow}, 32'd0);
        checkVal("b2b_ptr", {22'd0, ovWrPtr},   32'd7);

        // Clear request coincident with a new event: sweep first, then entry at 0.
        iClearReq = 1'b1; iEventValid = 1'b1; ivEventCode = 8'hC3; ivEventData = 8'h81;
        pushClear();
        pushEvent(8'hC3, 8'h81);
        step();
        iClearReq = 1'b0; iEventValid = 1'b0;
        checkVal("clr_busy", {31'd0, oClearBusy}, 32'd1);
        waitClearDone();
        waitDrain();
        checkVal("clr_ptr",  {22'd0, ovWrPtr},  32'd1);
        checkVal("clr_wrap", {31'd0, oWrapped}, 32'd0);

        // Six events during a sweep: four buffered, two dropped.
        iClearReq = 1'b1;
        pushClear();
        step();
        iClearReq = 1'b0;
        for (int i = 0; i < 6; i++) begin
            iEventValid = 1'b1; ivEventCode = 8'(8'h60 + i); ivEventData = 8'(i);
            if (i < 4) pushEvent(ivEventCode, ivEventData);
            step();
        end
        iEventValid = 1'b0;
        waitClearDone();
        waitDrain();
        checkVal("ovf_set", {31'd0, oOverflow}, 32'd1);
        checkVal("ovf_ptr", {22'd0, ovWrPtr},   32'd4);

        // Reset in the middle of a sweep.
        iClearReq = 1'b1;
        pushClear();
        step();
        iClearReq = 1'b0;
        repeat (499) step();
        iRst = 1'b1;
        step();
        iRst = 1'b0;
        expQ.delete();
        modelPtr = 10'd0; modelSeq = 16'h0000; tickCnt = 16'h0000;
        checkVal("abort_we",   {31'd0, oAppWE},     32'd0);
        checkVal("abort_busy", {31'd0, oClearBusy}, 32'd0);
        checkVal("abort_ptr",  {22'd0, ovWrPtr},    32'd0);
        checkVal("abort_ovf",  {31'd0, oOverflow},  32'd0);
        repeat (5) step();

        // 1025 events: pointer wraps, last entry lands at address 0.
        for (int i = 0; i < 1025; i++) begin
            iEventValid = 1'b1; ivEventCode = 8'(i); ivEventData = 8'((i >> 8) ^ 8'hA5);
            pushEvent(ivEventCode, ivEventData);
            step();
        end
        iEventValid = 1'b0;
        waitDrain();
        checkVal("wrap_flag", {31'd0, oWrapped},  32'd1);
        checkVal("wrap_ptr",  {22'd0, ovWrPtr},   32'd1);
        checkVal("wrap_ovf",  {31'd0, oOverflow}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCnt, missCnt);
        $finish;
    end

endmodule
